ddr_rd_splitter: RTL

//  Upstream feeder of the AXI read master. Takes one user read request
//  (start address, total beats up to 65535) and splits it into bursts of at

---
 rtl/ddr_rd_splitter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ddr_rd_splitter.sv
// Splits one user read request into column-safe bursts of at most RBURST_LEN beats.
// Latency: sum of bursts + 2 cycles per burst (CALC, TRIG) + 1 (DONE).
// Backpressure: one request in flight, no queueing; waits on rd_ready before each burst.
module ddr_rd_splitter #(
   parameter int         ADDR_WIDTH = 26,
   parameter int         COL_BITS   = 10,
   parameter logic [7:0] RBURST_LEN = 8'd8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_init_end,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [15:0]           i_req_len,
   output logic                  o_req_done,
   output logic                  o_beat_err,
   output logic                  o_rd_trig,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic [7:0]            o_rd_len,
   input  logic                  i_rd_ready,
   input  logic                  i_rd_done,
   input  logic                  i_rd_data_en
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CALC = 3'd1;
   localparam logic [2:0] S_TRIG = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // burst length arithmetic is done wide enough for a full column span and
   // the full 16-bit remaining count
   localparam int            BW       = (COL_BITS + 1 > 17) ? COL_BITS + 1 : 17;
   localparam logic [BW-1:0] COL_SPAN = BW'(1) << COL_BITS;

   logic [2:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_cur_addr;
   logic [15:0]           r_remain;
   logic [7:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [7:0]            r_rd_len;
   logic                  r_rd_trig;
   logic                  r_beat_err;

   logic                  w_req_ready;
   logic [BW-1:0]         w_room;
   logic [BW-1:0]         w_blen;
   logic [7:0]            w_cnt_nxt;
   logic [15:0]           w_remain_nxt;

   assign w_req_ready  = (r_state == S_IDLE) && i_init_end;
   assign w_cnt_nxt    = (i_rd_data_en && (r_cnt != 8'hFF)) ? r_cnt + 8'd1 : r_cnt;
   assign w_remain_nxt = r_remain - {8'h00, r_rd_len};

   assign o_req_ready = w_req_ready;
   assign o_req_done  = (r_state == S_DONE);
   assign o_beat_err  = r_beat_err;
   assign o_rd_trig   = r_rd_trig;
   assign o_rd_addr   = r_rd_addr;
   assign o_rd_len    = r_rd_len;

   // next burst length: smallest of max burst, remaining beats and room to column end
   always_comb begin
      w_room = COL_SPAN - BW'(r_cur_addr[COL_BITS-1:0]);
      w_blen = BW'(RBURST_LEN);
      if (BW'(r_remain) < w_blen) w_blen = BW'(r_remain);
      if (w_room < w_blen)        w_blen = w_room;
   end

   // request/burst sequencing, beat counting and sticky error
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cur_addr <= '0;
         r_remain   <= '0;
         r_cnt      <= '0;
         r_rd_addr  <= '0;
         r_rd_len   <= '0;
         r_rd_trig  <= 1'b0;
         r_beat_err <= 1'b0;
      end else begin
         r_rd_trig <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req_valid && w_req_ready) begin
                  r_cur_addr <= i_req_addr;
                  r_remain   <= i_req_len;
                  r_beat_err <= 1'b0;
                  r_state    <= (i_req_len == 16'd0) ? S_DONE : S_CALC;
               end
            end
            S_CALC: begin
               r_rd_addr <= r_cur_addr;
               r_rd_len  <= w_blen[7:0];
               r_cnt     <= '0;
               r_state   <= S_TRIG;
            end
            S_TRIG: begin
               if (i_rd_ready) begin
                  r_rd_trig <= 1'b1;
                  r_state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= w_cnt_nxt;
               if (i_rd_done) begin
                  if (w_cnt_nxt != r_rd_len) r_beat_err <= 1'b1;
                  r_cur_addr <= r_cur_addr + ADDR_WIDTH'(r_rd_len);
                  r_remain   <= w_remain_nxt;
                  r_state    <= (w_remain_nxt == 16'd0) ? S_DONE : S_CALC;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
